// File: rtl/pspi_rx_shifter.sv
// pspi_rx_shifter: serial-to-parallel receive shifter for a peripheral SPI (MISO) stream
//
// Receives DATA_W data bits, an optional parity bit and GUARD_BITS ignored
// idle slots, one per bit_en_i strobe. It then commits the word to pout_o
// with a data_valid_o / rd_ack_i handshake.
//
// Parameters
//   DATA_W      data bits per frame (2..32)
//   MSB_FIRST   1: first received bit lands in pout_o[DATA_W-1], 0: in pout_o[0]
//   PARITY_MODE 0: none, 1: even, 2: odd
//   GUARD_BITS  ignored bit slots after the parity/last data bit (0..3)
//   AUTO_START  1: frames follow back-to-back, 0: each frame needs frame_start_i
//
// Ports
//   clk_i          single clock, rising edge
//   rst_ni         asynchronous active-low reset
//   bit_en_i       one-clk strobe marking a valid sample of din_i
//   din_i          serial data
//   frame_start_i  arms reception from IDLE
//   rd_ack_i       consumer has taken pout_o
//   pout_o         last committed word
//   data_valid_o   pout_o holds an unacknowledged word
//   par_err_o      parity error of the word in pout_o
//   overrun_o      sticky: a completed frame was dropped
//   busy_o         receiver is not in IDLE
module pspi_rx_shifter #(
    parameter int DATA_W      = 8,
    parameter int MSB_FIRST   = 1,
    parameter int PARITY_MODE = 2,
    parameter int GUARD_BITS  = 1,
    parameter int AUTO_START  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bit_en_i,
    input  logic              din_i,
    input  logic              frame_start_i,
    input  logic              rd_ack_i,
    output logic [DATA_W-1:0] pout_o,
    output logic              data_valid_o,
    output logic              par_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_GUARD} state_e;

    // Five bits cover both the data index (up to 31) and the guard index (up to 2).
    localparam int              CW         = 5;
    localparam logic [CW-1:0]   LAST_DATA  = CW'(DATA_W - 1);
    localparam logic [CW-1:0]   LAST_GUARD = CW'(GUARD_BITS > 0 ? GUARD_BITS - 1 : 0);
    localparam bit              HAS_PAR    = PARITY_MODE != 0;
    localparam bit              HAS_GRD    = GUARD_BITS > 0;
    // The state entered both out of reset and after every completed frame.
    localparam state_e          ST_RELOAD  = (AUTO_START != 0) ? S_DATA : S_IDLE;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d, sh_next, word;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   pout_q, pout_d;
    logic                dv_q, dv_d;
    logic                pe_q, pe_d;
    logic                ov_q, ov_d;
    logic                data_x, par_bit, word_perr, commit;

    // The shift register with the current sample shifted in, in the configured order.
    assign sh_next = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], din_i}
                                      : {din_i, sh_q[DATA_W-1:1]};

    // In PARITY the shift register already holds the full word; din_i is the parity bit.
    assign data_x  = ^sh_q ^ din_i;
    assign par_bit = (PARITY_MODE == 1) ? data_x : ~data_x;

    // Frame sequencing: the state and counter only move on bit_en_i, except for leaving IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_en_i) begin
                    sh_d = sh_next;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d = '0;
                        if (HAS_PAR) begin
                            state_d = S_PARITY;
                        end else if (HAS_GRD) begin
                            state_d = S_GUARD;
                        end else begin
                            commit  = 1'b1;
                            state_d = ST_RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_en_i) begin
                    perr_d = par_bit;
                    if (HAS_GRD) begin
                        state_d = S_GUARD;
                    end else begin
                        commit  = 1'b1;
                        state_d = ST_RELOAD;
                    end
                end
            end
            S_GUARD: begin
                if (bit_en_i) begin
                    if (cnt_q == LAST_GUARD) begin
                        cnt_d   = '0;
                        commit  = 1'b1;
                        state_d = ST_RELOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RELOAD;
        endcase
    end

    // The word being committed.
    // - If the frame ends in DATA, the final sample is still on din_i.
    // - If the frame ends in PARITY, the parity result is still combinational.
    // - perr_q stays 0 forever when parity is disabled.
    assign word      = (state_q == S_DATA) ? sh_next : sh_q;
    assign word_perr = (state_q == S_PARITY) ? par_bit : perr_q;

    // Output handshake.
    // - An acknowledge on the commit edge frees the holding slot for the new word.
    // - Otherwise a pending word makes the new one drop and raises overrun.
    always_comb begin
        pout_d = pout_q;
        pe_d   = pe_q;
        dv_d   = dv_q;
        ov_d   = ov_q;
        if (commit && (!dv_q || rd_ack_i)) begin
            pout_d = word;
            pe_d   = word_perr;
            dv_d   = 1'b1;
            ov_d   = 1'b0;
        end else if (commit) begin
            ov_d   = 1'b1;
        end else if (rd_ack_i && dv_q) begin
            dv_d   = 1'b0;
            ov_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RELOAD;
            cnt_q   <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            pout_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            pout_q  <= pout_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            ov_q    <= ov_d;
        end
    end

    assign pout_o       = pout_q;
    assign data_valid_o = dv_q;
    assign par_err_o    = pe_q;
    assign overrun_o    = ov_q;
    assign busy_o       = state_q != S_IDLE;

endmodule

// File: tb/tb_pspi_rx_shifter.sv
// tb_pspi_rx_shifter: checks four pspi_rx_shifter configurations against a frame-level model
//
// The four instances see the same stimulus:
//   d0  defaults
//   d1  LSB first, even parity
//   d2  AUTO_START=0
//   d3  4-bit frames, no parity, no guard
module tb_pspi_rx_shifter;

    localparam int NI = 4;
    localparam int DW [NI] = '{8, 8, 8, 4};
    localparam int MF [NI] = '{1, 0, 1, 1};
    localparam int PM [NI] = '{2, 1, 2, 0};
    localparam int GB [NI] = '{1, 1, 1, 0};
    localparam int AS [NI] = '{1, 1, 0, 1};

    logic clk, rst_n, bit_en, din, frame_start, rd_ack;
    logic [7:0] p0, p1, p2;
    logic [3:0] p3;
    logic [NI-1:0] dv, pe, ov, bz;
    logic [31:0] dpo [NI];

    int n_chk = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pspi_rx_shifter u0 (.clk_i(clk), .rst_ni(rst_n), .bit_en_i(bit_en), .din_i(din),
        .frame_start_i(frame_start), .rd_ack_i(rd_ack), .pout_o(p0), .data_valid_o(dv[0]),
        .par_err_o(pe[0]), .overrun_o(ov[0]), .busy_o(bz[0]));
    pspi_rx_shifter #(.MSB_FIRST(0), .PARITY_MODE(1)) u1 (.clk_i(clk), .rst_ni(rst_n),
        .bit_en_i(bit_en), .din_i(din), .frame_start_i(frame_start), .rd_ack_i(rd_ack),
        .pout_o(p1), .data_valid_o(dv[1]), .par_err_o(pe[1]), .overrun_o(ov[1]), .busy_o(bz[1]));
    pspi_rx_shifter #(.AUTO_START(0)) u2 (.clk_i(clk), .rst_ni(rst_n), .bit_en_i(bit_en),
        .din_i(din), .frame_start_i(frame_start), .rd_ack_i(rd_ack), .pout_o(p2),
        .data_valid_o(dv[2]), .par_err_o(pe[2]), .overrun_o(ov[2]), .busy_o(bz[2]));
    pspi_rx_shifter #(.DATA_W(4), .PARITY_MODE(0), .GUARD_BITS(0)) u3 (.clk_i(clk),
        .rst_ni(rst_n), .bit_en_i(bit_en), .din_i(din), .frame_start_i(frame_start),
        .rd_ack_i(rd_ack), .pout_o(p3), .data_valid_o(dv[3]), .par_err_o(pe[3]),
        .overrun_o(ov[3]), .busy_o(bz[3]));

    assign dpo[0] = 32'(p0);
    assign dpo[1] = 32'(p1);
    assign dpo[2] = 32'(p2);
    assign dpo[3] = 32'(p3);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Frame-level model.
    // - Received bits of the current frame are collected in arrival order.
    // - Once the frame length is reached, the word is assembled by position.
    // - Parity is taken from the count of ones.
    logic        m_armed [NI];
    int          m_cnt   [NI];
    logic [63:0] m_bits  [NI];
    logic [31:0] m_pout  [NI];
    logic        m_dv [NI], m_pe [NI], m_ov [NI];
    logic [31:0] w;
    int          ones;
    logic        done, perr;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_armed[i] = AS[i] != 0;
                m_cnt[i]   = 0;
                m_bits[i]  = '0;
                m_pout[i]  = '0;
                m_dv[i]    = 1'b0;
                m_pe[i]    = 1'b0;
                m_ov[i]    = 1'b0;
            end else begin
                done = 1'b0;
                if (!m_armed[i]) begin
                    if (frame_start) m_armed[i] = 1'b1;
                end else if (bit_en) begin
                    m_bits[i][m_cnt[i]] = din;
                    m_cnt[i]++;
                    if (m_cnt[i] == DW[i] + (PM[i] != 0 ? 1 : 0) + GB[i]) done = 1'b1;
                end
                if (done) begin
                    w = '0;
                    for (int k = 0; k < DW[i]; k++) w[(MF[i] != 0) ? DW[i] - 1 - k : k] = m_bits[i][k];
                    ones = $countones(w) + ((PM[i] != 0) ? int'(m_bits[i][DW[i]]) : 0);
                    perr = (PM[i] == 0) ? 1'b0 : (PM[i] == 1) ? (ones % 2 != 0) : (ones % 2 == 0);
                    if (!m_dv[i] || rd_ack) begin
                        m_pout[i] = w;
                        m_pe[i]   = perr;
                        m_dv[i]   = 1'b1;
                        m_ov[i]   = 1'b0;
                    end else begin
                        m_ov[i]   = 1'b1;
                    end
                    m_cnt[i]   = 0;
                    m_armed[i] = AS[i] != 0;
                end else if (rd_ack && m_dv[i]) begin
                    m_dv[i] = 1'b0;
                    m_ov[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("d%0d.pout", i), dpo[i], m_pout[i]);
            chk($sformatf("d%0d.data_valid", i), 32'(dv[i]), 32'(m_dv[i]));
            chk($sformatf("d%0d.par_err", i), 32'(pe[i]), 32'(m_pe[i]));
            chk($sformatf("d%0d.overrun", i), 32'(ov[i]), 32'(m_ov[i]));
            chk($sformatf("d%0d.busy", i), 32'(bz[i]), 32'(m_armed[i]));
        end
    end

    // Inputs change 1 time unit after a rising edge and are consumed on the next one.
    task automatic step(input logic be, input logic d, input logic fs, input logic ack);
        bit_en = be;
        din = d;
        frame_start = fs;
        rd_ack = ack;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        frame_start = 1'b0;
        rd_ack = 1'b0;
    endtask

    task automatic data8(input logic [7:0] d);
        for (int k = 0; k < 8; k++) step(1'b1, d[7-k], 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic ack_last);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        data8(d);
        step(1'b1, p, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, ack_last);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bit_en = 1'b0;
        din = 1'b0;
        frame_start = 1'b0;
        rd_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy_auto", 32'(bz[0]), 32'd1);
        chk("rst.busy_noauto", 32'(bz[2]), 32'd0);
        chk("rst.pout", 32'(p0), 32'h0);
        chk("rst.dv", 32'(dv[0]), 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("release.dv", 32'(dv[0]), 32'd0);

        // A5, parity 1, guard: odd parity is correct, even parity is wrong.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        data8(8'hA5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("a5p1.dv_before_guard", 32'(dv[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("a5p1.pout", 32'(p0), 32'hA5);
        chk("a5p1.par_err_odd", 32'(pe[0]), 32'd0);
        chk("a5p1.dv", 32'(dv[0]), 32'd1);
        chk("a5p1.lsb_pout", 32'(p1), 32'hA5);
        chk("a5p1.par_err_even", 32'(pe[1]), 32'd1);
        chk("a5p1.noauto_idle", 32'(bz[2]), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack.dv", 32'(dv[0]), 32'd0);

        // A5, parity 0.
        do_reset();
        frame(8'hA5, 1'b0, 1'b0);
        chk("a5p0.pout", 32'(p0), 32'hA5);
        chk("a5p0.par_err_odd", 32'(pe[0]), 32'd1);
        chk("a5p0.lsb_pout", 32'(p1), 32'hA5);
        chk("a5p0.par_err_even", 32'(pe[1]), 32'd0);

        // Overrun: the second word is dropped while the first is unacknowledged.
        do_reset();
        frame(8'h3C, 1'b1, 1'b0);
        frame(8'hC3, 1'b1, 1'b0);
        chk("ovr.pout", 32'(p0), 32'h3C);
        chk("ovr.overrun", 32'(ov[0]), 32'd1);
        chk("ovr.dv", 32'(dv[0]), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_ack.dv", 32'(dv[0]), 32'd0);
        chk("ovr_ack.overrun", 32'(ov[0]), 32'd0);

        // An acknowledge on the commit edge accepts the new word.
        do_reset();
        frame(8'h3C, 1'b1, 1'b0);
        frame(8'hC3, 1'b1, 1'b1);
        chk("ackcommit.pout", 32'(p0), 32'hC3);
        chk("ackcommit.dv", 32'(dv[0]), 32'd1);
        chk("ackcommit.overrun", 32'(ov[0]), 32'd0);

        // Reset mid-frame leaves no residue.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort.busy_noauto", 32'(bz[2]), 32'd0);
        chk("abort.busy_auto", 32'(bz[0]), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h5A, 1'b1, 1'b0);
        chk("abort.pout", 32'(p2), 32'h5A);
        chk("abort.par_err", 32'(pe[2]), 32'd0);
        chk("abort.dv", 32'(dv[2]), 32'd1);

        // 4-bit frames with no parity and no guard; an idle instance ignores bit_en.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("w4.pout", 32'(p3), 32'hB);
        chk("w4.dv", 32'(dv[3]), 32'd1);
        chk("w4.par_err", 32'(pe[3]), 32'd0);
        chk("w4.busy", 32'(bz[3]), 32'd1);
        chk("idle.busy", 32'(bz[2]), 32'd0);
        chk("idle.dv", 32'(dv[2]), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
